// File: rtl/ins_mem_loader.sv
// ---------------------------------------------------------------------------
// ins_mem_loader
//   Writer side of the instruction-memory interface. It takes a byte stream
//   framed as LEN_HI, LEN_LO (16-bit word count N) followed by 4*N bytes.
//   Bytes arrive MSB first and are assembled into big-endian 32-bit words.
//   Word k is written to InsMem word address k. The CPU is held through
//   cpu_hold until a complete image has been loaded.
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   start      in   1   1-cycle pulse; begins a load (taken in IDLE/DONE/ERR)
//   in_valid   in   1   byte-stream valid
//   in_data    in   8   byte-stream data
//   in_ready   out  1   loader can accept a byte this cycle
//   mem_we     out  1   InsMem write strobe, one pulse per word
//   mem_addr   out  32  word address (upper bits zero)
//   mem_wdata  out  32  assembled instruction word
//   cpu_hold   out  1   1 = CPU frozen; 0 only while DONE
//   done       out  1   level, 1 while DONE
//   err        out  1   level, 1 while ERR (length too large)
//
// Handshake: a byte transfers on a rising clk edge where in_valid and
// in_ready are both 1. in_ready does not depend on in_valid. The source may
// hold in_valid low for any number of cycles. mem_addr/mem_wdata are only
// meaningful while mem_we is 1, and they hold their values otherwise.
// ---------------------------------------------------------------------------
module ins_mem_loader #(
   parameter int ADDR_W = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_hold,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_HI = 3'd1,
      S_LEN_LO = 3'd2,
      S_DATA   = 3'd3,
      S_WRITE  = 3'd4,
      S_DONE   = 3'd5,
      S_ERR    = 3'd6
   } state_t;

   // Largest legal word count: the whole memory.
   localparam logic [16:0] CAP = 17'(1) << ADDR_W;

   state_t            state;
   logic [15:0]       len;
   logic [1:0]        byte_cnt;
   logic [ADDR_W:0]   word_cnt;
   logic [23:0]       shift;

   logic              accept;
   logic [16:0]       len_full;
   logic [ADDR_W:0]   word_next;

   assign accept    = in_valid && in_ready;
   // Full 16-bit length as it becomes known on the LEN_LO byte.
   assign len_full  = {1'b0, len[15:8], in_data};
   // k is at most 2**ADDR_W-1 in WRITE, so k+1 always fits in ADDR_W+1 bits.
   assign word_next = word_cnt + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         in_ready  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_hold  <= 1'b1;
         done      <= 1'b0;
         err       <= 1'b0;
         len       <= '0;
         byte_cnt  <= '0;
         word_cnt  <= '0;
         shift     <= '0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state    <= S_LEN_HI;
                  in_ready <= 1'b1;
                  cpu_hold <= 1'b1;
                  done     <= 1'b0;
                  err      <= 1'b0;
                  byte_cnt <= '0;
                  word_cnt <= '0;
               end
            end
            S_LEN_HI: begin
               if (accept) begin
                  len[15:8] <= in_data;
                  state     <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (accept) begin
                  len[7:0] <= in_data;
                  if (len_full == 17'd0) begin
                     state    <= S_DONE;
                     in_ready <= 1'b0;
                     cpu_hold <= 1'b0;
                     done     <= 1'b1;
                  end else if (len_full > CAP) begin
                     // Rejected before any data byte, so nothing is written.
                     state    <= S_ERR;
                     in_ready <= 1'b0;
                     err      <= 1'b1;
                  end else begin
                     state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (accept) begin
                  shift    <= {shift[15:0], in_data};
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     // Fourth byte: present the word during the WRITE cycle.
                     state     <= S_WRITE;
                     in_ready  <= 1'b0;
                     mem_we    <= 1'b1;
                     mem_addr  <= 32'(word_cnt[ADDR_W-1:0]);
                     mem_wdata <= {shift, in_data};
                  end
               end
            end
            S_WRITE: begin
               word_cnt <= word_next;
               if (17'(word_next) == {1'b0, len}) begin
                  state    <= S_DONE;
                  cpu_hold <= 1'b0;
                  done     <= 1'b1;
               end else begin
                  state    <= S_DATA;
                  in_ready <= 1'b1;
               end
            end
            default: begin
               state    <= S_IDLE;
               in_ready <= 1'b0;
               cpu_hold <= 1'b1;
               done     <= 1'b0;
               err      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ins_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_ins_mem_loader
//   Directed bench for ins_mem_loader (ADDR_W = 8). Inputs change 1 ns after
//   a rising edge. Outputs are checked 1 ns after the edge or on the falling
//   edge. Every InsMem write seen on mem_we is logged and compared against an
//   expected queue of hand-computed words.
// ---------------------------------------------------------------------------
module tb_ins_mem_loader;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_hold;
   logic        done;
   logic        err;

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_q[$];
   logic [31:0] exp_addr_q[$];
   logic [31:0] got_q[$];
   logic [31:0] got_addr_q[$];

   ins_mem_loader #(.ADDR_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_hold  (cpu_hold),
      .done      (done),
      .err       (err)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- write logger ----------------
   always @(negedge clk) begin
      if (rst_n === 1'b1 && mem_we === 1'b1) begin
         got_q.push_back(mem_wdata);
         got_addr_q.push_back(mem_addr);
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   // Offers one byte and waits (bounded) until it is accepted.
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = b;
      @(negedge clk);
      while (in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("byte_accept_timeout", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
      exp_addr_q.push_back(a);
      exp_q.push_back(d);
   endtask

   task automatic check_writes(input string tag);
      check({tag, "_wr_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         check({tag, "_wr_addr"}, got_addr_q.pop_front(), exp_addr_q.pop_front());
         check({tag, "_wr_data"}, got_q.pop_front(), exp_q.pop_front());
      end
      exp_q.delete();
      exp_addr_q.delete();
      got_q.delete();
      got_addr_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"},  {31'd0, in_ready}, 32'd0);
      check({tag, "_mem_we"},    {31'd0, mem_we},   32'd0);
      check({tag, "_mem_addr"},  mem_addr,          32'd0);
      check({tag, "_mem_wdata"}, mem_wdata,         32'd0);
      check({tag, "_cpu_hold"},  {31'd0, cpu_hold}, 32'd1);
      check({tag, "_done"},      {31'd0, done},     32'd0);
      check({tag, "_err"},       {31'd0, err},      32'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      tick(2);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick(2);
      check("idle_in_ready", {31'd0, in_ready}, 32'd0);

      // 1: two-word image
      pulse_start();
      check("t1_len_hi_ready", {31'd0, in_ready}, 32'd1);
      check("t1_hold_loading", {31'd0, cpu_hold}, 32'd1);
      send_byte(8'h00); send_byte(8'h02);
      send_byte(8'h20); send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
      check("t1_we_word0", {31'd0, mem_we}, 32'd1);
      check("t1_ready_in_write", {31'd0, in_ready}, 32'd0);
      send_byte(8'h08); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      check("t1_we_word1", {31'd0, mem_we}, 32'd1);
      check("t1_addr_word1", mem_addr, 32'd1);
      check("t1_hold_in_write", {31'd0, cpu_hold}, 32'd1);
      tick(1);
      check("t1_done", {31'd0, done}, 32'd1);
      check("t1_hold_released", {31'd0, cpu_hold}, 32'd0);
      check("t1_we_dropped", {31'd0, mem_we}, 32'd0);
      check("t1_wdata_held", mem_wdata, 32'h0800_0000);
      expect_write(32'd0, 32'h2001_0005);
      expect_write(32'd1, 32'h0800_0000);
      check_writes("t1");

      // 2: empty image, restarted from DONE
      pulse_start();
      check("t2_hold_after_start", {31'd0, cpu_hold}, 32'd1);
      check("t2_done_cleared", {31'd0, done}, 32'd0);
      send_byte(8'h00); send_byte(8'h00);
      check("t2_done", {31'd0, done}, 32'd1);
      check("t2_hold", {31'd0, cpu_hold}, 32'd0);
      check("t2_ready", {31'd0, in_ready}, 32'd0);
      tick(2);
      check_writes("t2");

      // 3: oversize N=257, stray bytes, recovery
      pulse_start();
      send_byte(8'h01); send_byte(8'h01);
      check("t3_err", {31'd0, err}, 32'd1);
      check("t3_hold", {31'd0, cpu_hold}, 32'd1);
      check("t3_done", {31'd0, done}, 32'd0);
      in_valid = 1'b1; in_data = 8'hAA;
      tick(3);
      check("t3_stray_ready", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b0;
      check_writes("t3");
      pulse_start();
      check("t3_recover_ready", {31'd0, in_ready}, 32'd1);
      check("t3_recover_err", {31'd0, err}, 32'd0);

      // 3b: N=0x1000 is rejected on the full 16-bit value
      send_byte(8'h10); send_byte(8'h00);
      check("t3b_err", {31'd0, err}, 32'd1);
      tick(2);
      check_writes("t3b");

      // 3c: N=256 fills the whole memory
      pulse_start();
      send_byte(8'h01); send_byte(8'h00);
      for (int i = 0; i < 256; i++) begin
         logic [7:0] b;
         b = 8'(i);
         send_byte(b); send_byte(~b); send_byte(8'h5A); send_byte(b);
         expect_write(32'(i), {b, ~b, 8'h5A, b});
      end
      tick(1);
      check("t3c_done", {31'd0, done}, 32'd1);
      check("t3c_last_addr", mem_addr, 32'd255);
      check_writes("t3c");

      // 4: N=1 with gaps on in_valid
      pulse_start();
      send_byte(8'h00); tick(1);
      send_byte(8'h01); tick(1);
      send_byte(8'hDE); tick(1);
      send_byte(8'hAD); tick(1);
      send_byte(8'hBE); tick(1);
      send_byte(8'hEF);
      in_valid = 1'b1; in_data = 8'h77;
      check("t4_we", {31'd0, mem_we}, 32'd1);
      check("t4_ready_in_write", {31'd0, in_ready}, 32'd0);
      tick(1);
      check("t4_done", {31'd0, done}, 32'd1);
      check("t4_ready_in_done", {31'd0, in_ready}, 32'd0);
      tick(2);
      in_valid = 1'b0;
      expect_write(32'd0, 32'hDEAD_BEEF);
      check_writes("t4");

      // 5: reset after two of three words
      pulse_start();
      send_byte(8'h00); send_byte(8'h03);
      send_byte(8'h11); send_byte(8'h11); send_byte(8'h11); send_byte(8'h11);
      send_byte(8'h22); send_byte(8'h22); send_byte(8'h22); send_byte(8'h22);
      send_byte(8'h33); send_byte(8'h33);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("t5_async");
      tick(2);
      rst_n = 1'b1;
      tick(1);
      expect_write(32'd0, 32'h1111_1111);
      expect_write(32'd1, 32'h2222_2222);
      check_writes("t5");

      // 6: start during DATA is ignored, then restart from DONE
      pulse_start();
      send_byte(8'h00); send_byte(8'h01);
      send_byte(8'h11); send_byte(8'h22);
      pulse_start();
      check("t6_ready_after_stray_start", {31'd0, in_ready}, 32'd1);
      send_byte(8'h33); send_byte(8'h44);
      tick(1);
      check("t6_done", {31'd0, done}, 32'd1);
      check("t6_hold", {31'd0, cpu_hold}, 32'd0);
      expect_write(32'd0, 32'h1122_3344);
      check_writes("t6");
      pulse_start();
      check("t6_restart_hold", {31'd0, cpu_hold}, 32'd1);
      check("t6_restart_ready", {31'd0, in_ready}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
